// File: rtl/uart_receiver.sv
// UART receiver: recovers 8N1 frames from an asynchronous serial line and
// presents each byte on a held-until-acknowledged valid/ack interface.
// Framing errors give a one-cycle pulse; a good frame that arrives while a
// byte is still unacknowledged is dropped and raises a sticky overrun flag.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bitValue,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT >> 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             sync1_reg;
    logic             sync2_reg;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic             shift_reg [8];
    logic [7:0]       shift_byte;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             frame_err_reg;

    // Decoded events for the current cycle
    logic             start_tick;
    logic             bit_tick;
    logic             data_sample;
    logic             stop_good;
    logic             stop_bad;
    logic             accept;

    assign rx_s = sync2_reg;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= bitValue;
            sync2_reg <= sync1_reg;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sample-point decode shared by next-state, datapath and output logic
    always_comb begin
        start_tick  = (state_reg == START) && (cnt_reg == HALF_LAST);
        bit_tick    = (cnt_reg == BIT_LAST);
        data_sample = (state_reg == DATA) && bit_tick;
        stop_good   = (state_reg == STOP) && bit_tick && rx_s;
        stop_bad    = (state_reg == STOP) && bit_tick && !rx_s;
        accept      = stop_good && (!valid_reg || ack);
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (start_tick) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (data_sample && (idx_reg == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (stop_good)     state_next = IDLE;
                else if (stop_bad) state_next = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Clock counter and bit index; every state change restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            idx_reg <= 3'd0;
        end else begin
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (state_reg == DATA && bit_tick) begin
                cnt_reg <= '0;
            end else if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (state_reg == START) begin
                idx_reg <= 3'd0;
            end else if (data_sample && (idx_reg != 3'd7)) begin
                idx_reg <= idx_reg + 3'd1;
            end
        end
    end

    // Shift register: each data bit lands directly in its own position
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shift_reg[gi] <= 1'b0;
            end else if (data_sample && (idx_reg == 3'(gi))) begin
                shift_reg[gi] <= rx_s;
            end
        end
        assign shift_byte[gi] = shift_reg[gi];
    end

    // Output registers: byte hand-off, overrun tracking, framing-error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= stop_bad;
            if (accept) begin
                // A same-cycle ack frees the slot, so the new byte is not an overrun
                data_reg    <= shift_byte;
                valid_reg   <= 1'b1;
                overrun_reg <= 1'b0;
            end else begin
                if (valid_reg && ack) begin
                    valid_reg   <= 1'b0;
                    overrun_reg <= 1'b0;
                end
                if (stop_good) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    // Output decode
    always_comb begin
        busy      = (state_reg != IDLE);
        data      = data_reg;
        valid     = valid_reg;
        overrun   = overrun_reg;
        frame_err = frame_err_reg;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It is the receive end paired with the team's uart_transmitter.
- Samples an asynchronous serial line at CLKS_PER_BIT clocks per bit and recovers 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Presents each byte on a held-until-acknowledged valid/ack interface to downstream logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16: clocks per serial bit. Must be >= 4. HALF = CLKS_PER_BIT>>1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- bitValue  input  1  serial line. Idle high. Asynchronous to clk.
- ack  input  1  consumer acknowledge; clears valid and overrun.
- data  output  8  last good received byte; held until the next good byte is accepted.
- valid  output  1  data holds an unacknowledged byte (level signal).
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky; a good frame arrived while valid=1 and was dropped.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE. Both synchronizer flops set to 1. Bit and clock counters cleared.
  - Reset mid-frame aborts the frame; no output event is produced.
- Synchronizer:
  - bitValue passes through 2 flops to give rx_s.
  - All decisions use rx_s. Line-to-FSM latency is 2 clocks.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s=0 -> START, clock counter=0.
- START:
  - Count to HALF-1, then sample rx_s.
  - Sample 0 -> DATA, counter=0, bit index=0.
  - Sample 1 -> glitch; go to IDLE with no output.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift register bit [index]. Data is LSB first.
  - After index 7 is sampled -> STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample 1, valid=0 or ack=1 that same cycle: data<=shift, valid<=1 -> IDLE.
  - Sample 1, valid=1 and ack=0: data unchanged, overrun<=1, byte dropped -> IDLE.
  - Sample 0: frame_err pulses for 1 clock, data/valid unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s=1, then -> IDLE.
  - A break condition (line held low) therefore yields exactly one frame_err.
- Sample timing:
  - Bit k (start=0, d0..d7=1..8, stop=9) is sampled HALF + k*CLKS_PER_BIT clocks after the first clock with rx_s=0.
  - valid rises on the following edge.
- ack handling:
  - ack with valid=1 clears valid and overrun on the next edge.
  - ack with valid=0 has no effect.
  - ack in the same cycle as a good stop sample: the new byte is loaded, valid stays 1, no overrun.
- Back-to-back frames:
  - A start edge seen the cycle after STOP->IDLE is accepted. Zero idle time between frames is supported.
- Counters:
  - Clock counter width = $clog2(CLKS_PER_BIT). Bit index is 3 bits.
  - No wrap beyond 7; a new frame restarts both counters.

Test Plan:
- Use CLKS_PER_BIT=4 for all scenarios.
- Reset then idle line: all outputs 0 throughout; busy=0.
- Good frame 0x96:
  - Drive 0, then 0,1,1,0,1,0,0,1, then 1; each bit held 4 clocks.
  - Required: data=0x96 and valid=1 one clock after the stop sample; frame_err=0.
  - Assert ack for 1 clock -> valid=0; data remains 0x96.
- Back-to-back 0x0E then 0x96 without ack:
  - data=0x0E, valid=1, overrun=1 after the second frame; data is not 0x96.
  - ack clears valid and overrun together.
- Glitch: line low for 1 clock only, then high -> back to IDLE, no valid, no frame_err.
- Framing error:
  - Frame 0x55 with stop bit 0, then line held low for 20 clocks.
  - Exactly one frame_err pulse; valid unchanged; busy=1 until the line returns high.
  - A following good frame 0xA5 is received correctly.
- Reset mid-frame: assert rst during DATA bit 3 -> all outputs 0 immediately; the next frame 0x3C is received correctly.
